// File: rtl/fetch_decode.sv
// Fetch/decode front end: PC register, synchronous instruction ROM interface,
// registered decode of the instruction word into Execute's control bundle,
// branch redirect with wrong-path squash, and a sticky halt.
module fetch_decode #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned UOP_B    = 9,
    parameter int unsigned UOP_HLT  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_rdata,
    input  logic              global_disable,
    input  logic [31:0]       delta_instruction,
    output logic              num_to_rhs,
    output logic [31:0]       num,
    output logic [3:0]        sel_p0,
    output logic [3:0]        sel_p1,
    output logic [3:0]        sel_in,
    output logic [4:0]        uop,
    output logic [3:0]        branch_cond,
    output logic [ADDR_W-1:0] exec_pc,
    output logic              halted
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned UOP_W  = 5;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned IMM_W  = 18;
    localparam int unsigned BOFF_W = 22;

    // Control bundle handed to Execute; all-zero is a NOP.
    typedef struct packed {
        logic              num_to_rhs;
        logic [DATA_W-1:0] num;
        logic [REG_W-1:0]  sel_p0;
        logic [REG_W-1:0]  sel_p1;
        logic [REG_W-1:0]  sel_in;
        logic [UOP_W-1:0]  uop;
        logic [REG_W-1:0]  branch_cond;
    } bundle_t;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_n;
    logic [ADDR_W-1:0] pc_d_q;
    logic [ADDR_W-1:0] pc_d_n;
    logic [ADDR_W-1:0] exec_pc_n;
    logic              v_d_q;
    logic              v_d_n;
    logic              halted_n;
    logic              redirect_c;
    logic              imm_c;
    bundle_t           dec_c;
    bundle_t           bundle_q;
    bundle_t           bundle_n;
    logic              unused_delta_hi;

    // Only the low ADDR_W bits of the word offset matter; addresses wrap.
    assign unused_delta_hi = ^delta_instruction[DATA_W-1:ADDR_W];

    // Redirects are ignored once halted.
    assign redirect_c = global_disable && !halted;

    assign imem_addr = pc_q;
    assign imem_en   = !halted;

    // Decode the ROM data word; branch offset takes precedence over the imm flag.
    always_comb begin
        dec_c             = '0;
        imm_c             = imem_rdata[26];
        dec_c.uop         = imem_rdata[31:27];
        dec_c.sel_in      = imem_rdata[25:22];
        dec_c.branch_cond = imem_rdata[25:22];
        dec_c.sel_p0      = imem_rdata[21:18];
        dec_c.sel_p1      = imm_c ? '0 : imem_rdata[17:14];
        if (dec_c.uop == UOP_W'(UOP_B)) begin
            dec_c.num        = {{(DATA_W-BOFF_W){imem_rdata[BOFF_W-1]}}, imem_rdata[BOFF_W-1:0]};
            dec_c.num_to_rhs = 1'b1;
        end else if (imm_c) begin
            dec_c.num        = {{(DATA_W-IMM_W){1'b0}}, imem_rdata[IMM_W-1:0]};
            dec_c.num_to_rhs = 1'b1;
        end
    end

    // Next-state: halt freezes fetch, redirect squashes, otherwise advance.
    always_comb begin
        pc_n      = pc_q;
        pc_d_n    = pc_d_q;
        v_d_n     = 1'b0;
        exec_pc_n = exec_pc;
        halted_n  = halted;
        bundle_n  = '0;
        if (halted) begin
            v_d_n = 1'b0;
        end else if (redirect_c) begin
            pc_n      = exec_pc + delta_instruction[ADDR_W-1:0];
            v_d_n     = 1'b0;
            exec_pc_n = pc_d_q;
        end else begin
            pc_n      = pc_q + ADDR_W'(1);
            pc_d_n    = pc_q;
            v_d_n     = 1'b1;
            exec_pc_n = pc_d_q;
            if (v_d_q) begin
                bundle_n = dec_c;
                if (dec_c.uop == UOP_W'(UOP_HLT)) begin
                    halted_n = 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= ADDR_W'(RESET_PC);
            pc_d_q   <= '0;
            v_d_q    <= 1'b0;
            exec_pc  <= '0;
            halted   <= 1'b0;
            bundle_q <= '0;
        end else begin
            pc_q     <= pc_n;
            pc_d_q   <= pc_d_n;
            v_d_q    <= v_d_n;
            exec_pc  <= exec_pc_n;
            halted   <= halted_n;
            bundle_q <= bundle_n;
        end
    end

    assign num_to_rhs  = bundle_q.num_to_rhs;
    assign num         = bundle_q.num;
    assign sel_p0      = bundle_q.sel_p0;
    assign sel_p1      = bundle_q.sel_p1;
    assign sel_in      = bundle_q.sel_in;
    assign uop         = bundle_q.uop;
    assign branch_cond = bundle_q.branch_cond;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode with a synchronous ROM model.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst4_n = 1'b0;
    logic [9:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = '0;
    logic        global_disable = 1'b0;
    logic [31:0] delta_instruction = '0;
    logic        num_to_rhs;
    logic [31:0] num;
    logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
    logic [4:0]  uop;
    logic [9:0]  exec_pc;
    logic        halted;

    logic [3:0]  imem_addr4, exec_pc4;
    logic        imem_en4, num_to_rhs4, halted4;
    logic [31:0] num4;
    logic [3:0]  sel_p04, sel_p14, sel_in4, branch_cond4;
    logic [4:0]  uop4;

    logic [31:0] rom [0:1023];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Synchronous ROM: holds data while disabled.
    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

    fetch_decode dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_rdata(imem_rdata), .global_disable(global_disable),
        .delta_instruction(delta_instruction), .num_to_rhs(num_to_rhs), .num(num),
        .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in), .uop(uop),
        .branch_cond(branch_cond), .exec_pc(exec_pc), .halted(halted)
    );

    fetch_decode #(.ADDR_W(4)) u4 (
        .clk(clk), .rst_n(rst4_n), .imem_addr(imem_addr4), .imem_en(imem_en4),
        .imem_rdata(32'd0), .global_disable(1'b0),
        .delta_instruction(32'd0), .num_to_rhs(num_to_rhs4), .num(num4),
        .sel_p0(sel_p04), .sel_p1(sel_p14), .sel_in(sel_in4), .uop(uop4),
        .branch_cond(branch_cond4), .exec_pc(exec_pc4), .halted(halted4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 32'd0;
    endtask

    initial begin
        // Program A: MOV imm, ADD, branch, ADD, branch-with-imm-flag
        clear_rom();
        rom[0] = {5'd8, 1'b1, 4'd1, 4'd0, 18'h0CAFE};
        rom[1] = {5'd1, 1'b0, 4'd4, 4'd1, 4'd2, 14'd0};
        rom[2] = {5'd9, 1'b0, 4'hA, 22'h3FFFFE};
        rom[3] = {5'd2, 1'b0, 4'd3, 4'd5, 4'd6, 14'd0};
        rom[4] = {5'd9, 1'b1, 4'h3, 22'h200001};

        step(); step();
        check("rst_uop", 32'(uop), 32'd0);
        check("rst_num", num, 32'd0);
        check("rst_ntr", 32'(num_to_rhs), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_en", 32'(imem_en), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_exec_pc", 32'(exec_pc), 32'd0);

        rst_n = 1'b1;
        step();
        check("e1_bubble", 32'(uop), 32'd0);
        step();
        check("mov_uop", 32'(uop), 32'd8);
        check("mov_ntr", 32'(num_to_rhs), 32'd1);
        check("mov_num", num, 32'h0000CAFE);
        check("mov_sel_in", 32'(sel_in), 32'd1);
        check("mov_sel_p1", 32'(sel_p1), 32'd0);
        check("mov_exec_pc", 32'(exec_pc), 32'd0);
        step();
        check("add_uop", 32'(uop), 32'd1);
        check("add_p0", 32'(sel_p0), 32'd1);
        check("add_p1", 32'(sel_p1), 32'd2);
        check("add_in", 32'(sel_in), 32'd4);
        check("add_num", num, 32'd0);
        check("add_ntr", 32'(num_to_rhs), 32'd0);
        check("add_exec_pc", 32'(exec_pc), 32'd1);
        step();
        check("br_uop", 32'(uop), 32'd9);
        check("br_cond", 32'(branch_cond), 32'hA);
        check("br_num", num, 32'hFFFFFFFE);
        check("br_ntr", 32'(num_to_rhs), 32'd1);
        check("br_exec_pc", 32'(exec_pc), 32'd2);
        step();
        check("add2_uop", 32'(uop), 32'd2);
        check("add2_p1", 32'(sel_p1), 32'd6);
        check("add2_exec_pc", 32'(exec_pc), 32'd3);
        step();
        check("brimm_num", num, 32'hFFE00001);
        check("brimm_p1", 32'(sel_p1), 32'd0);
        check("brimm_exec_pc", 32'(exec_pc), 32'd4);
        step();
        check("pre_redir_exec_pc", 32'(exec_pc), 32'd5);

        // Redirect by -3 from exec_pc 5
        global_disable = 1'b1;
        delta_instruction = 32'hFFFFFFFD;
        step();
        global_disable = 1'b0;
        check("redir_addr", 32'(imem_addr), 32'd2);
        check("redir_bub1", 32'(uop), 32'd0);
        step();
        check("redir_bub2", 32'(uop), 32'd0);
        step();
        check("redir_tgt_uop", 32'(uop), 32'd9);
        check("redir_tgt_pc", 32'(exec_pc), 32'd2);

        // Negative delta wrapping below zero
        global_disable = 1'b1;
        delta_instruction = 32'hFFFFFFFB;
        step();
        global_disable = 1'b0;
        check("wrap_neg_addr", 32'(imem_addr), 32'd1021);

        // Program B: HLT at address 3
        rst_n = 1'b0;
        clear_rom();
        rom[0] = {5'd1, 1'b0, 4'd1, 4'd1, 4'd1, 14'd0};
        rom[1] = rom[0];
        rom[2] = rom[0];
        rom[3] = {5'd31, 27'd0};
        step(); step();
        rst_n = 1'b1;
        repeat (5) step();
        check("hlt_uop", 32'(uop), 32'd31);
        check("hlt_exec_pc", 32'(exec_pc), 32'd3);
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_en", 32'(imem_en), 32'd0);
        check("hlt_addr", 32'(imem_addr), 32'd5);
        global_disable = 1'b1;
        delta_instruction = 32'd16;
        step();
        check("hlt_nop1", 32'(uop), 32'd0);
        check("hlt_ignore_redir", 32'(imem_addr), 32'd5);
        global_disable = 1'b0;
        step();
        check("hlt_nop2", 32'(uop), 32'd0);
        check("hlt_sticky", 32'(halted), 32'd1);
        check("hlt_frozen", 32'(imem_addr), 32'd5);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_uop", 32'(uop), 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_en", 32'(imem_en), 32'd1);
        check("arst_exec_pc", 32'(exec_pc), 32'd0);

        // HLT squashed by a redirect while in the ROM stage
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("sq_exec_pc", 32'(exec_pc), 32'd2);
        global_disable = 1'b1;
        delta_instruction = 32'd10;
        step();
        global_disable = 1'b0;
        check("sq_uop", 32'(uop), 32'd0);
        check("sq_halted", 32'(halted), 32'd0);
        check("sq_addr", 32'(imem_addr), 32'd12);
        step(); step();
        check("sq_halted_later", 32'(halted), 32'd0);
        check("sq_en", 32'(imem_en), 32'd1);

        // 4-bit address space wraps 15 -> 0
        rst4_n = 1'b1;
        repeat (15) step();
        check("w4_addr15", 32'(imem_addr4), 32'd15);
        step();
        check("w4_addr0", 32'(imem_addr4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
